// File: rtl/conv33_window_buffer.sv
// 3x3 sliding-window buffer feeding the convolution input controller.
// Two line buffers hold the previous rows; the stream stalls per window.
module conv33_window_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pixel_in,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  output logic [9*DATA_W-1:0] window,
  output logic                input_valid,
  output logic                inputbuf_load,
  input  logic                inputbuf_read_en,
  input  logic                input_ready,
  output logic                frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [2:0] {
    STREAM,
    ANNOUNCE,
    LOAD,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last_win;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win [9];

  logic accept;
  logic col_end;
  logic row_end;
  logic win_ok;

  assign accept  = pixel_valid && pixel_ready;
  assign col_end = (col == CW'(IMG_W - 1));
  assign row_end = (row == RW'(IMG_H - 1));
  assign win_ok  = (row >= RW'(2)) && (col >= CW'(2));

  always_comb begin
    window = '0;
    for (int k = 0; k < 9; k++) begin
      window[k*DATA_W +: DATA_W] = win[k];
    end
  end

  // lb0 holds row-2, lb1 holds row-1 at each column
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STREAM;
      col           <= '0;
      row           <= '0;
      last_win      <= 1'b0;
      pixel_ready   <= 1'b0;
      input_valid   <= 1'b0;
      inputbuf_load <= 1'b0;
      frame_done    <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win[k] <= '0;
      end
    end else begin
      unique case (state)
        STREAM: begin
          pixel_ready <= 1'b1;
          if (accept) begin
            for (int r = 0; r < 3; r++) begin
              win[r*3]   <= win[r*3+1];
              win[r*3+1] <= win[r*3+2];
            end
            win[2] <= lb0[col];
            win[5] <= lb1[col];
            win[8] <= pixel_in;
            if (col_end) begin
              col <= '0;
              row <= row_end ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (win_ok) begin
              state       <= ANNOUNCE;
              pixel_ready <= 1'b0;
              input_valid <= 1'b1;
              last_win    <= col_end && row_end;
            end
          end
        end
        ANNOUNCE: begin
          state         <= LOAD;
          inputbuf_load <= 1'b1;
        end
        LOAD: begin
          if (inputbuf_read_en) begin
            state         <= BUSY;
            input_valid   <= 1'b0;
            inputbuf_load <= 1'b0;
          end
        end
        BUSY: begin
          if (input_ready) begin
            if (last_win) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end else begin
              state       <= STREAM;
              pixel_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= STREAM;
          frame_done  <= 1'b0;
          pixel_ready <= 1'b1;
          col         <= '0;
          row         <= '0;
        end
        default: begin
          state <= STREAM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv33_window_buffer.sv
// Bench for conv33_window_buffer: directed frames plus random pixel data,
// checked against windows computed straight from the image array.
module tb_conv33_window_buffer;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int N    = W * H;
  localparam int TOTW = (W - 2) * (H - 2);
  localparam int WW   = 9 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic [WW-1:0] window;
  logic          input_valid;
  logic          inputbuf_load;
  logic          inputbuf_read_en = 1'b0;
  logic          input_ready = 1'b0;
  logic          frame_done;

  int checks = 0;
  int failures = 0;
  int fd_seen = 0;
  int frames_exp = 0;
  bit aborted;

  logic [DW-1:0] img [N];

  conv33_window_buffer #(
    .DATA_W(DW),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_in        (pixel_in),
    .pixel_valid     (pixel_valid),
    .pixel_ready     (pixel_ready),
    .window          (window),
    .input_valid     (input_valid),
    .inputbuf_load   (inputbuf_load),
    .inputbuf_read_en(inputbuf_read_en),
    .input_ready     (input_ready),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_seen++;
  end

  task automatic chk(input string tag,
                     input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp_v);
    end
  endtask

  // Window anchored at its newest pixel (r, c)
  function automatic logic [WW-1:0] ref_win(input int r,
                                            input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[(i*3+j)*DW +: DW] = img[(r-2+i)*W + (c-2+j)];
      end
    end
    return w;
  endfunction

  task automatic do_reset_check();
    rst = 1'b1;
    #1;
    chk("rst_pixel_ready", pixel_ready, 0);
    chk("rst_input_valid", input_valid, 0);
    chk("rst_inputbuf_load", inputbuf_load, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_window", window, 0);
    pixel_valid = 1'b0;
    inputbuf_read_en = 1'b0;
    input_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit gap,
                           input int stall,
                           input int abort_win,
                           output bit ab);
    logic [WW-1:0] expq[$];
    int idx, nwin, phase, lcnt, budget, r, c;
    bit acc, exp_load, rd, rdy, fin, last_pend;
    idx = 0; nwin = 0; phase = 0; lcnt = 0;
    budget = 0; exp_load = 0; fin = 0;
    last_pend = 0; ab = 0;
    for (int rr = 2; rr < H; rr++) begin
      for (int cc = 2; cc < W; cc++) begin
        expq.push_back(ref_win(rr, cc));
      end
    end
    while (!fin && budget < 2000) begin
      pixel_valid = (idx < N) &&
                    (gap ? ($urandom_range(0, 1) == 1) : 1'b1);
      pixel_in = (idx < N) ? img[idx] : DW'($urandom);
      rd = 0;
      rdy = 0;
      if (phase == 0 && inputbuf_load === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL load_window observed=extra expected=none");
        end else begin
          chk("load_window", window, expq[0]);
        end
        chk("load_pixel_ready", pixel_ready, 0);
        chk("load_input_valid", input_valid, 1);
        if (lcnt >= stall) begin
          rd = 1;
          phase = 1;
        end
        lcnt++;
      end else if (phase == 2) begin
        rdy = 1;
      end else if (gap) begin
        rd = ($urandom_range(0, 3) == 0);
        rdy = ($urandom_range(0, 3) == 0);
      end
      inputbuf_read_en = rd;
      input_ready = rdy;
      acc = pixel_valid && (pixel_ready === 1'b1);
      @(posedge clk);
      #1;
      budget++;
      if (exp_load) begin
        chk("lat_load", inputbuf_load, 1);
        chk("lat_valid2", input_valid, 1);
        exp_load = 0;
      end
      if (acc) begin
        r = idx / W;
        c = idx % W;
        idx++;
        if (r >= 2 && c >= 2) begin
          chk("lat_valid1", input_valid, 1);
          chk("lat_noload", inputbuf_load, 0);
          chk("lat_ready_low", pixel_ready, 0);
          exp_load = 1;
        end else begin
          chk("stream_valid", input_valid, 0);
          chk("stream_ready", pixel_ready, 1);
        end
      end
      if (phase == 1) begin
        chk("busy_valid", input_valid, 0);
        chk("busy_load", inputbuf_load, 0);
        chk("busy_ready", pixel_ready, 0);
        chk("busy_frame_done", frame_done, 0);
        if (expq.size() > 0) void'(expq.pop_front());
        nwin++;
        phase = 2;
        if (nwin == abort_win) begin
          #2;
          do_reset_check();
          ab = 1;
          return;
        end
      end else if (phase == 2 && rdy) begin
        if (nwin == TOTW) begin
          chk("frame_done_pulse", frame_done, 1);
          chk("done_ready", pixel_ready, 0);
          last_pend = 1;
        end else begin
          chk("mid_frame_done", frame_done, 0);
          chk("resume_ready", pixel_ready, 1);
        end
        phase = 0;
        lcnt = 0;
      end else if (last_pend) begin
        chk("frame_done_clear", frame_done, 0);
        chk("next_frame_ready", pixel_ready, 1);
        fin = 1;
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $error("FAIL timeout observed=%0d windows expected=%0d",
             nwin, TOTW);
    end
    chk("window_count", nwin, TOTW);
    frames_exp++;
  endtask

  task automatic load_seq(input int base);
    for (int i = 0; i < N; i++) img[i] = DW'(base + i);
  endtask

  initial begin
    #3;
    do_reset_check();

    // Plain stream, immediate controller
    load_seq(1);
    run_frame(0, 0, 0, aborted);

    // Controller stalls in LOAD
    run_frame(0, 5, 0, aborted);

    // Gapped input with stray strobes
    run_frame(1, 0, 0, aborted);

    // Reset while busy on window 2, then fresh frame
    run_frame(0, 0, 2, aborted);
    chk("abort_taken", aborted, 1);
    run_frame(0, 0, 0, aborted);

    // Back-to-back frames without reset
    load_seq(1);
    run_frame(0, 0, 0, aborted);
    load_seq(101);
    run_frame(0, 0, 0, aborted);
    chk("b2b_first_window", ref_win(2, 2),
        {8'd111, 8'd110, 8'd109, 8'd107, 8'd106,
         8'd105, 8'd103, 8'd102, 8'd101});

    // Random pixel data, gaps, random stalls
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) img[i] = DW'($urandom);
      run_frame(1, $urandom_range(0, 3), 0, aborted);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("frame_done_total", fd_seen, frames_exp);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
